// File: rtl/rijndael_pkg.sv
// Shared Rijndael definitions: Nb select encoding and row-offset/width helpers.
package rijndael_pkg;

  typedef enum logic [1:0] {
    NB4     = 2'b00,
    NB6     = 2'b01,
    NB8     = 2'b10,
    NB_RSVD = 2'b11
  } nb_sel_e;

  // Returns 0 for the reserved encoding so callers can flag it as illegal.
  function automatic int unsigned nb_cols(nb_sel_e sel);
    case (sel)
      NB4:     return 4;
      NB6:     return 6;
      NB8:     return 8;
      default: return 0;
    endcase
  endfunction

  // Nb=8 uses offsets {0,1,3,4}; smaller blocks use {0,1,2,3}.
  function automatic int unsigned row_shift(int unsigned nb, int unsigned row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

  function automatic int unsigned statesize(int unsigned nb);
    return 32 * nb;
  endfunction

endpackage

// File: rtl/rijndael_shiftrows_core.sv
// Combinational ShiftRows permutation for Nb = 4/6/8.
// Inverse direction only compiled with RIJNDAEL_SHIFTROWS_INV_EN.
module rijndael_shiftrows_core
  import rijndael_pkg::*;
#(
  parameter int NB_MAX    = 8,
  parameter int STATESIZE = 32 * NB_MAX
) (
  input  logic [STATESIZE-1:0] in_state,
  input  nb_sel_e              nb_sel,
  input  logic                 inv,
  output logic [STATESIZE-1:0] out_state,
  output logic                 err
);

`ifndef RIJNDAEL_SHIFTROWS_INV_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

  always_comb begin
    int unsigned nb;
    int unsigned sh;
    int unsigned src;
    out_state = '0;
    err       = 1'b0;
    nb        = nb_cols(nb_sel);
    sh        = 0;
    src       = 0;
    if (nb == 0 || nb > NB_MAX) begin
      out_state = in_state;
      err       = 1'b1;
    end else begin
      for (int c = 0; c < NB_MAX; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (c < nb) begin
            sh = row_shift(nb, r);
            // sh < nb and c < nb, so one conditional subtract wraps the index.
`ifdef RIJNDAEL_SHIFTROWS_INV_EN
            src = inv ? (c + nb - sh) : (c + sh);
`else
            src = c + sh;
`endif
            if (src >= nb) src = src - nb;
            out_state[STATESIZE-1-(32*c+8*r) -: 8] = in_state[STATESIZE-1-(32*src+8*r) -: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/rijndael_shiftrows_pipe.sv
// Elastic valid/ready pipeline around the ShiftRows core (permutation ahead of stage 0).
// Inverse mode available when RIJNDAEL_SHIFTROWS_INV_EN is defined.
module rijndael_shiftrows_pipe
  import rijndael_pkg::*;
#(
  parameter int NB_MAX      = 8,
  parameter int PIPE_STAGES = 1,
  localparam int STATESIZE  = statesize(NB_MAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [STATESIZE-1:0] in_state,
  input  logic [1:0]           in_nb_sel,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STATESIZE-1:0] out_state,
  output logic [1:0]           out_nb_sel,
  output logic                 out_err
);

  typedef struct packed {
    logic [STATESIZE-1:0] state;
    logic [1:0]           nb_sel;
    logic                 err;
  } stage_t;

  logic [STATESIZE-1:0]   core_state;
  logic                   core_err;
  stage_t                 head;
  stage_t                 stg [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_pipe;
  logic [PIPE_STAGES-1:0] ld;

  rijndael_shiftrows_core #(
    .NB_MAX   (NB_MAX),
    .STATESIZE(STATESIZE)
  ) u_core (
    .in_state (in_state),
    .nb_sel   (nb_sel_e'(in_nb_sel)),
    .inv      (in_inv),
    .out_state(core_state),
    .err      (core_err)
  );

  assign head = '{state: core_state, nb_sel: in_nb_sel, err: core_err};

  // Ready ripples back from the output: a stage loads if empty or if it drains this cycle.
  always_comb begin
    ld = '0;
    ld[PIPE_STAGES-1] = !vld_pipe[PIPE_STAGES-1] || out_ready;
    for (int k = PIPE_STAGES - 2; k >= 0; k--)
      ld[k] = !vld_pipe[k] || ld[k+1];
  end

  assign in_ready = ld[0];

  // Payload only captured alongside a valid, so bubbles never disturb held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) stg[k] <= '0;
    end else begin
      if (ld[0]) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) stg[0] <= head;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (ld[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) stg[k] <= stg[k-1];
        end
      end
    end
  end

  assign out_valid  = vld_pipe[PIPE_STAGES-1];
  assign out_state  = stg[PIPE_STAGES-1].state;
  assign out_nb_sel = stg[PIPE_STAGES-1].nb_sel;
  assign out_err    = stg[PIPE_STAGES-1].err;

endmodule

// File: tb/tb_rijndael_shiftrows_pipe.sv
// Self-checking bench: directed ShiftRows vectors plus randomized elastic traffic vs a byte-matrix model.
module tb_rijndael_shiftrows_pipe;

  localparam int NB_MAX = 8;
  localparam int PS     = 3;
  localparam int SS     = 32 * NB_MAX;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_inv, out_valid, out_ready, out_err;
  logic [SS-1:0] in_state, out_state;
  logic [1:0]    in_nb_sel, out_nb_sel;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rijndael_shiftrows_pipe #(.NB_MAX(NB_MAX), .PIPE_STAGES(PS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_nb_sel(in_nb_sel), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_nb_sel(out_nb_sel), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [SS+3:0] got, input logic [SS+3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: treat the state as a 4 x Nb byte matrix and rotate each row by its offset.
  function automatic logic [SS:0] ref_model(input logic [SS-1:0] s, input logic [1:0] sel, input logic inv);
    int nb;
    int offs [4];
    int src;
    logic [SS-1:0] res;
    case (sel)
      2'd0: nb = 4;
      2'd1: nb = 6;
      2'd2: nb = 8;
      default: nb = 0;
    endcase
    if (nb == 0 || nb > NB_MAX) return {1'b1, s};
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
`ifdef RIJNDAEL_SHIFTROWS_INV_EN
        src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
`else
        src = (c + offs[r]) % nb;
`endif
        res[SS-1-(32*c+8*r) -: 8] = s[SS-1-(32*src+8*r) -: 8];
      end
    return {1'b0, res};
  endfunction

  function automatic logic [SS-1:0] rand_state();
    logic [SS-1:0] v;
    for (int i = 0; i < SS / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Single transaction through an idle pipeline; returns the result and its latency.
  task automatic send_one(input logic [SS-1:0] s, input logic [1:0] sel, input logic inv,
                          output logic [SS-1:0] os, output logic [1:0] onb, output logic oerr,
                          output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_state = s; in_nb_sel = sel; in_inv = inv; out_ready = 1'b1;
    #1 chk("ready_idle", {{SS+3{1'b0}}, in_ready}, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    if (!out_valid) chk("out_timeout", 0, 1);
    os = out_state; onb = out_nb_sel; oerr = out_err;
  endtask

  typedef struct {
    logic [SS-1:0] st;
    logic [1:0]    nb;
    logic          err;
  } exp_t;

  exp_t q[$];
  logic          stall_prev = 1'b0;
  logic [SS+3:0] prev_out;

  // One cycle of random traffic: pop-check, push-model, and hold-stability check.
  task automatic run_cycle(input bit traffic);
    exp_t e;
    logic [SS:0] m;
    @(negedge clk);
    if (stall_prev)
      chk("hold_stable", {out_valid, out_nb_sel, out_err, out_state}, prev_out);
    in_valid  = traffic && ($urandom_range(0, 3) != 0);
    in_state  = rand_state();
    in_nb_sel = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    in_inv    = 1'($urandom);
    out_ready = traffic ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("stream_data", {1'b0, out_nb_sel, out_err, out_state}, {1'b0, e.nb, e.err, e.st});
      end
    end
    if (in_valid && in_ready) begin
      m = ref_model(in_state, in_nb_sel, in_inv);
      q.push_back('{st: m[SS-1:0], nb: in_nb_sel, err: m[SS]});
    end
    stall_prev = out_valid && !out_ready;
    prev_out   = {out_valid, out_nb_sel, out_err, out_state};
  endtask

  initial begin
    logic [SS-1:0] os, s;
    logic [1:0]    onb;
    logic          oerr;
    logic [SS:0]   m;
    int            lat;
    logic [127:0]  p4, p4_fwd;

    p4     = 128'h000102030405060708090A0B0C0D0E0F;
    p4_fwd = 128'h00050A0F04090E03080D02070C01060B;

    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_nb_sel = 2'd0; in_inv = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {{SS+3{1'b0}}, out_valid}, 0);
    chk("rst_out_state", {4'h0, out_state}, 0);
    chk("rst_nb_err", {{SS+1{1'b0}}, out_nb_sel, out_err}, 0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", {{SS+3{1'b0}}, in_ready}, 1);

    // Nb=4 forward, junk in unused columns must come out zero.
    send_one({p4, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF}, 2'd0, 1'b0, os, onb, oerr, lat);
    chk("nb4_fwd", {4'h0, os}, {4'h0, p4_fwd, 128'h0});
    chk("nb4_fwd_err", {{SS+1{1'b0}}, onb, oerr}, 0);
    chk("latency", SS + 4'(lat), SS + 4'(PS - 1));

    // Inverse of the forward result (falls back to forward when inverse is not built).
    send_one({p4_fwd, 128'h0}, 2'd0, 1'b1, os, onb, oerr, lat);
`ifdef RIJNDAEL_SHIFTROWS_INV_EN
    chk("nb4_inv", {4'h0, os}, {4'h0, p4, 128'h0});
`else
    m = ref_model({p4_fwd, 128'h0}, 2'd0, 1'b0);
    chk("nb4_inv_disabled", {4'h0, os}, {4'h0, m[SS-1:0]});
`endif

    // Nb=8 forward with bytes 00..1F.
    for (int i = 0; i < 32; i++) s[SS-1-8*i -: 8] = 8'(i);
    send_one(s, 2'd2, 1'b0, os, onb, oerr, lat);
    chk("nb8_r2c0", {{SS-4{1'b0}}, os[SS-17 -: 8]}, 8'h0E);
    chk("nb8_r3c0", {{SS-4{1'b0}}, os[SS-25 -: 8]}, 8'h13);
    m = ref_model(s, 2'd2, 1'b0);
    chk("nb8_full", {3'h0, oerr, os}, {3'h0, m});

    // Reserved select passes the state through and flags the error.
    s = {(SS/8){8'hA5}};
    send_one(s, 2'd3, 1'b0, os, onb, oerr, lat);
    chk("rsvd_state", {4'h0, os}, {4'h0, s});
    chk("rsvd_nb_err", {{SS+1{1'b0}}, onb, oerr}, {{SS+1{1'b0}}, 2'b11, 1'b1});

    // Nb=6 random, both directions.
    for (int i = 0; i < 2; i++) begin
      s = rand_state();
      send_one(s, 2'd1, 1'(i), os, onb, oerr, lat);
      m = ref_model(s, 2'd1, 1'(i));
      chk("nb6_rand", {1'b0, onb, oerr, os}, {1'b0, 2'd1, m});
    end

    // Randomized elastic traffic, then drain.
    for (int i = 0; i < 300; i++) run_cycle(1'b1);
    for (int i = 0; i < 20 && q.size() != 0; i++) run_cycle(1'b0);
    chk("drain_empty", SS + 4'(q.size()), SS);

    // Mid-stream reset discards everything in flight.
    for (int i = 0; i < 15; i++) run_cycle(1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_valid", {{SS+3{1'b0}}, out_valid}, 0);
    chk("midrst_state", {4'h0, out_state}, 0);
    q.delete();
    stall_prev = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_ready", {{SS+3{1'b0}}, in_ready}, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {3'h0, out_valid, out_state}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rijndael_shiftrows_pipe.md
# rijndael_shiftrows_pipe

Pipelined, runtime-configurable ShiftRows stage for the Rijndael datapath. Each transaction selects the block width (Nb = 4, 6 or 8 columns) and the direction (forward or inverse). A valid/ready elastic pipeline carries the result so the stage can sit between the SubBytes and MixColumns stages of a round engine without external stall logic.

## Interface
Parameters:
- NB_MAX, 8: largest supported Nb; legal values are 4, 6, 8. State bus width is STATESIZE = 32*NB_MAX.
- PIPE_STAGES, 1: number of register stages; legal range 1..4.

Ports:
- clk  in  1  clock; the only clock in the block.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_state  in  STATESIZE  input state, column-major, byte (row r, col c) at bits [STATESIZE-1-(32c+8r) -: 8].
- in_nb_sel  in  2  Nb select: 00 = 4, 01 = 6, 10 = 8, 11 = reserved.
- in_inv  in  1  0 = forward ShiftRows, 1 = inverse ShiftRows.
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts the output.
- out_state  out  STATESIZE  shifted state.
- out_nb_sel  out  2  in_nb_sel of this transaction, passed through.
- out_err  out  1  the transaction had an illegal Nb select.

## Operation
- Row offsets s_r: {0,1,2,3} for Nb = 4 or 6; {0,1,3,4} for Nb = 8.
- Forward: out[r][c] = in[r][(c + s_r) mod Nb]. Inverse: out[r][c] = in[r][(c - s_r + Nb) mod Nb], computed without negative intermediates.
- Only columns 0..Nb-1 (the MSB end) are significant. Output bytes in columns ≥ Nb are driven to 0x00.
- Illegal select (11, or Nb > NB_MAX):
  - out_state = in_state unmodified.
  - out_err = 1.
  - The transaction still flows normally and is never dropped.
- The permutation is evaluated combinationally before stage 0. Stages 1..PIPE_STAGES-1 carry data only.
- Each stage holds valid, state, nb_sel and err.
- Stage k loads when it is empty, or when its contents move on this cycle. The last stage's contents move when out_ready = 1; every other stage's contents move when stage k+1 loads.
- in_ready = load enable of stage 0. The ready path is combinational through all stages.
- out_* reflect the last stage.
- Order is preserved; there is no reordering, duplication or loss.

## Timing
- Reset (async assert, sync release): all stage valids = 0, out_valid = 0, out_state = 0, out_nb_sel = 00, out_err = 0.
- in_ready is 1 in the first cycle after release.
- Reset asserted mid-operation discards all in-flight transactions immediately.
- Latency: an input accepted at edge t appears on out_valid after edge t+PIPE_STAGES-1, i.e. it is visible in the cycle following edge t+PIPE_STAGES-1.
- Throughput: 1 transaction per cycle while out_ready = 1.
- Full pipeline with out_ready = 0:
  - in_ready = 0.
  - All stage contents hold stable.
  - out_* stay stable while out_valid = 1 and out_ready = 0.
- Full pipeline with out_ready = 1 and in_valid = 1 in the same cycle: output pops and input loads on the same edge (pass-through, no bubble).
- in_valid = 0 leaves bubbles; bubbles are filled as upstream stalls clear.

## Configuration
- RIJNDAEL_SHIFTROWS_INV_EN defined: inverse mode is available as described.
- RIJNDAEL_SHIFTROWS_INV_EN undefined: inverse logic is not compiled. in_inv is ignored and every transaction uses the forward permutation. out_err is not affected by in_inv.

## Structure
- Shared package rijndael_pkg holds:
  - nb_sel_e enum (NB4, NB6, NB8, NB_RSVD).
  - function nb_cols(nb_sel_e).
  - function row_shift(nb, row).
  - function statesize(nb).
- Sub-module rijndael_shiftrows_core: purely combinational permutation (in_state, nb_sel, inv → out_state, err). It is instantiated once, ahead of stage 0.
- The pipeline registers and handshake live in rijndael_shiftrows_pipe.

## Test plan
Notation: bytes are listed MSB first; pattern P4 = bytes 00..0F with byte index 4c+r.
- NB_MAX=4, forward, in_state = P4 → out_state = 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B, out_err = 0, visible PIPE_STAGES cycles after acceptance.
- Inverse of that output (macro defined) → 00..0F. With the macro undefined, in_inv = 1 yields the forward result.
- NB_MAX=8, Nb = 8, forward, bytes 00..1F → row 2 output column 0 = 0E (col 3, row 2). Row 3 output column 0 = 13 (col 4, row 3).
- NB_MAX=8, Nb = 4, P4 in the upper 128 bits with LSB bytes = FF → upper 128 bits match scenario 1, lower 128 bits = 0.
- in_nb_sel = 11 with state 0xA5… → out_state = in_state, out_err = 1, out_nb_sel = 11.
- PIPE_STAGES = 3, stream 10 transactions with random out_ready and in_valid; then assert rst_n low mid-stream. Required: in-order delivery with no loss, out_* stable while stalled, and after reset out_valid = 0 and out_state = 0 with no further outputs.
